pcileech_sys_reset_ctl: RTL and testbench

- System reset, input-conditioning and wake sequencer for the Screamer M2 top level.
- Sits upstream of the com, fifo and PCIe stages and replaces the free-running tick-count reset.
- Generates the synchronous fabric reset, the FT601 reset and the power-on LED blink.
- Synchronizes and debounces pcie_perst_n and pcie_present, and sequences PCIe WAKE# on request.

---
 rtl/pcileech_sys_reset_ctl_if.sv | 42 ++++
 rtl/pcileech_sys_reset_ctl.sv | 174 +++++++++++++++++
 tb/tb_pcileech_sys_reset_ctl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pcileech_sys_reset_ctl_if.sv
// Signal bundle between the system reset / conditioning / wake block and
// the rest of the Screamer M2 top level. The slave side is the controller
// itself. The master side is whatever drives the pads and the wake request
// and consumes the resets.
interface pcileech_sys_reset_ctl_if;
    logic        pcie_perst_n_in;
    logic        pcie_present_in;
    logic        wake_req;
    logic        rst;
    logic        ft601_rst_n;
    logic        pcie_perst_n_sync;
    logic        pcie_present_sync;
    logic        pcie_wake_n;
    logic        led_pwronblink;
    logic [63:0] tickcount64;

    modport slave (
        input  pcie_perst_n_in,
        input  pcie_present_in,
        input  wake_req,
        output rst,
        output ft601_rst_n,
        output pcie_perst_n_sync,
        output pcie_present_sync,
        output pcie_wake_n,
        output led_pwronblink,
        output tickcount64
    );

    modport master (
        output pcie_perst_n_in,
        output pcie_present_in,
        output wake_req,
        input  rst,
        input  ft601_rst_n,
        input  pcie_perst_n_sync,
        input  pcie_present_sync,
        input  pcie_wake_n,
        input  led_pwronblink,
        input  tickcount64
    );
endinterface

// File: rtl/pcileech_sys_reset_ctl.sv
// System reset, input conditioning and PCIe WAKE# sequencer.
// - Holds the fabric reset for a fixed number of cycles after rst_n release.
// - Synchronizes and debounces PERST# and present.
// - Drives WAKE# low on request until the host resumes, the card goes away
//   or a timeout expires. A holdoff period then blocks new requests.
module pcileech_sys_reset_ctl #(
    parameter int unsigned  PARAM_RST_CYCLES      = 64,
    parameter int unsigned  PARAM_DEBOUNCE_CYCLES = 1024,
    parameter logic [31:0]  PARAM_WAKE_TIMEOUT    = 32'd100000000,
    parameter logic [31:0]  PARAM_WAKE_HOLDOFF    = 32'd1000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pcileech_sys_reset_ctl_if.slave     sys
);

    localparam int unsigned DW       = $clog2(PARAM_DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(PARAM_DEBOUNCE_CYCLES - 1);
    localparam logic [63:0]   RST_LAST = 64'(PARAM_RST_CYCLES - 1);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_ASSERT  = 2'd1,
        W_HOLDOFF = 2'd2
    } wake_state_t;

    logic [63:0] tickcount_reg;
    logic        rst_reg;
    logic        rst_next;
    logic        ft601_rst_n_reg;
    logic        led_reg;

    // Index 0 carries PERST#, index 1 carries present.
    logic        pad_in  [2];
    logic        deb_out [2];

    wake_state_t state_reg;
    wake_state_t state_next;
    logic [31:0] wcnt_reg;
    logic [31:0] wcnt_next;
    logic        wake_n_reg;

    // Free-running cycle counter, wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tickcount_reg <= '0;
        end else begin
            tickcount_reg <= tickcount_reg + 64'd1;
        end
    end

    // Release is sticky: once the count passes the last reset edge, rst stays low.
    // That includes a wrap of the counter.
    assign rst_next = rst_reg & (tickcount_reg != RST_LAST);

    // Fabric and FT601 resets, released together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_reg         <= 1'b1;
            ft601_rst_n_reg <= 1'b0;
        end else begin
            rst_reg         <= rst_next;
            ft601_rst_n_reg <= ~rst_next;
        end
    end

    // Blink during roughly the first second after power-on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg <= 1'b0;
        end else begin
            led_reg <= tickcount_reg[24] & (tickcount_reg[63:27] == 37'd0);
        end
    end

    assign pad_in[0] = sys.pcie_perst_n_in;
    assign pad_in[1] = sys.pcie_present_in;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic          sync1_reg;
            logic          sync2_reg;
            logic          out_reg;
            logic          out_next;
            logic [DW-1:0] cnt_reg;
            logic [DW-1:0] cnt_next;

            // Debounce: the output toggles only after the synchronized input
            // has disagreed with it for the full run of cycles.
            always_comb begin
                out_next = out_reg;
                cnt_next = '0;
                if (sync2_reg != out_reg) begin
                    if (cnt_reg == DEB_LAST) begin
                        out_next = ~out_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            // Two-flop synchronizer followed by the debounce state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    out_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pad_in[gi];
                    sync2_reg <= sync1_reg;
                    out_reg   <= out_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign deb_out[gi] = out_reg;
        end
    endgenerate

    // Wake sequencer next-state logic. A request is honoured only from idle,
    // out of reset, with the card present and the host still holding PERST#.
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg + 32'd1;
        case (state_reg)
            W_IDLE: begin
                wcnt_next = '0;
                if (sys.wake_req && !rst_reg && deb_out[1] && !deb_out[0]) begin
                    state_next = W_ASSERT;
                end
            end
            W_ASSERT: begin
                if (deb_out[0] || !deb_out[1] ||
                    (wcnt_reg == PARAM_WAKE_TIMEOUT - 32'd1)) begin
                    state_next = W_HOLDOFF;
                    wcnt_next  = '0;
                end
            end
            W_HOLDOFF: begin
                if (wcnt_reg == PARAM_WAKE_HOLDOFF - 32'd1) begin
                    state_next = W_IDLE;
                    wcnt_next  = '0;
                end
            end
            default: begin
                state_next = W_IDLE;
                wcnt_next  = '0;
            end
        endcase
    end

    // Wake sequencer state, counter and registered WAKE# pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= W_IDLE;
            wcnt_reg   <= '0;
            wake_n_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            wcnt_reg   <= wcnt_next;
            wake_n_reg <= (state_next != W_ASSERT);
        end
    end

    assign sys.rst               = rst_reg;
    assign sys.ft601_rst_n       = ft601_rst_n_reg;
    assign sys.pcie_perst_n_sync = deb_out[0];
    assign sys.pcie_present_sync = deb_out[1];
    assign sys.pcie_wake_n       = wake_n_reg;
    assign sys.led_pwronblink    = led_reg;
    assign sys.tickcount64       = tickcount_reg;

endmodule

// File: tb/tb_pcileech_sys_reset_ctl.sv
// Directed bench for the system reset / conditioning / wake sequencer.
// It uses small debounce, timeout and holdoff values so every corner is
// reachable within a few hundred cycles.
module tb_pcileech_sys_reset_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pcileech_sys_reset_ctl_if sys_if ();

    pcileech_sys_reset_ctl #(
        .PARAM_RST_CYCLES      (64),
        .PARAM_DEBOUNCE_CYCLES (4),
        .PARAM_WAKE_TIMEOUT    (32'd100),
        .PARAM_WAKE_HOLDOFF    (32'd20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sys   (sys_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic perst_in;
        logic pres_in;
        logic wake;
        int   cyc;
        logic e_wake_n;
        logic e_perst;
        logic e_pres;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // After rst_n is released at a negedge, observe edges 1..70.
    // A wake request at edge 10 must be blocked while rst is high.
    task automatic rst_seq(input string tag);
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (i == 10) sys_if.wake_req = 1'b1;
            if (i == 11) sys_if.wake_req = 1'b0;
            check({tag, "_rst"}, 64'(sys_if.rst), 64'(i < 64));
            check({tag, "_ft601"}, 64'(sys_if.ft601_rst_n), 64'(i >= 64));
            check({tag, "_tick"}, sys_if.tickcount64, 64'(i));
            check({tag, "_wake_blk"}, 64'(sys_if.pcie_wake_n), 64'd1);
        end
        check({tag, "_led"}, 64'(sys_if.led_pwronblink), 64'd0);
        check({tag, "_pres_sync"}, 64'(sys_if.pcie_present_sync), 64'd1);
        $display("reset sequence %s: rst=%0b tick=%0d", tag, sys_if.rst, sys_if.tickcount64);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        int rises;
        int cnt;
        logic prev;

        //                perst pres wake cyc  wake_n perst_s pres_s
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1};  // wake accepted
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1};  // perst not yet through
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1};  // perst_sync at 6
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b1};  // wake released +1
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 25, 1'b1, 1'b1, 1'b1};  // holdoff elapses
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 2,  1'b1, 1'b1, 1'b1};  // blocked: perst_sync=1
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 6,  1'b1, 1'b0, 1'b1};  // perst falls
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 6,  1'b1, 1'b0, 1'b0};  // present falls
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2,  1'b1, 1'b0, 1'b0};  // blocked: present=0
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 6,  1'b1, 1'b0, 1'b1};  // present back
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1};  // wake accepted
        vecs[11] = '{1'b0, 1'b0, 1'b0, 6,  1'b0, 1'b0, 1'b0};  // present_sync drops
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0};  // forced holdoff
        vecs[13] = '{1'b0, 1'b1, 1'b0, 25, 1'b1, 1'b0, 1'b1};  // back to idle

        sys_if.pcie_perst_n_in = 1'b0;
        sys_if.pcie_present_in = 1'b1;
        sys_if.wake_req        = 1'b0;

        // Reset state while rst_n is held low.
        repeat (3) @(negedge clk);
        check("por_rst", 64'(sys_if.rst), 64'd1);
        check("por_ft601", 64'(sys_if.ft601_rst_n), 64'd0);
        check("por_tick", sys_if.tickcount64, 64'd0);
        check("por_wake_n", 64'(sys_if.pcie_wake_n), 64'd1);
        check("por_perst_sync", 64'(sys_if.pcie_perst_n_sync), 64'd0);
        check("por_pres_sync", 64'(sys_if.pcie_present_sync), 64'd0);
        check("por_led", 64'(sys_if.led_pwronblink), 64'd0);
        $display("power-on reset state checked");

        rst_n = 1'b1;
        rst_seq("por");

        // A 3-cycle glitch must not reach the output.
        sys_if.pcie_perst_n_in = 1'b1;
        repeat (3) @(negedge clk);
        sys_if.pcie_perst_n_in = 1'b0;
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sys_if.pcie_perst_n_sync) highs++;
        end
        check("glitch3_highs", 64'(highs), 64'd0);
        $display("glitch 3 cycles: highs=%0d", highs);

        // A 4-cycle pulse produces exactly one output pulse.
        sys_if.pcie_perst_n_in = 1'b1;
        repeat (4) @(negedge clk);
        sys_if.pcie_perst_n_in = 1'b0;
        rises = 0;
        prev = sys_if.pcie_perst_n_sync;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (sys_if.pcie_perst_n_sync && !prev) rises++;
            prev = sys_if.pcie_perst_n_sync;
        end
        check("pulse4_rises", 64'(rises), 64'd1);
        check("pulse4_final", 64'(sys_if.pcie_perst_n_sync), 64'd0);
        $display("pulse 4 cycles: rises=%0d", rises);

        // Table-driven wake and debounce vectors.
        for (int v = 0; v < 14; v++) begin
            sys_if.pcie_perst_n_in = vecs[v].perst_in;
            sys_if.pcie_present_in = vecs[v].pres_in;
            sys_if.wake_req        = vecs[v].wake;
            for (int c = 0; c < vecs[v].cyc; c++) begin
                @(negedge clk);
                sys_if.wake_req = 1'b0;
            end
            check($sformatf("vec%0d_wake_n", v), 64'(sys_if.pcie_wake_n), 64'(vecs[v].e_wake_n));
            check($sformatf("vec%0d_perst", v), 64'(sys_if.pcie_perst_n_sync), 64'(vecs[v].e_perst));
            check($sformatf("vec%0d_pres", v), 64'(sys_if.pcie_present_sync), 64'(vecs[v].e_pres));
            $display("vec %0d: wake_n=%0b perst_sync=%0b pres_sync=%0b", v,
                     sys_if.pcie_wake_n, sys_if.pcie_perst_n_sync, sys_if.pcie_present_sync);
        end

        // The timeout holds WAKE# low for exactly 100 cycles.
        sys_if.wake_req = 1'b1;
        @(negedge clk);
        sys_if.wake_req = 1'b0;
        cnt = 0;
        while (sys_if.pcie_wake_n == 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_low_cycles", 64'(cnt), 64'd100);
        $display("timeout: wake_n low for %0d cycles", cnt);

        // Requests during the 20-cycle holdoff are ignored. The 21st is accepted.
        sys_if.wake_req = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            check($sformatf("holdoff_j%0d", j), 64'(sys_if.pcie_wake_n), 64'd1);
        end
        @(negedge clk);
        sys_if.wake_req = 1'b0;
        check("holdoff_j21_accept", 64'(sys_if.pcie_wake_n), 64'd0);
        $display("holdoff: request at cycle 21 wake_n=%0b", sys_if.pcie_wake_n);

        // Asynchronous reset in the middle of W_ASSERT.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wake_n", 64'(sys_if.pcie_wake_n), 64'd1);
        check("async_rst", 64'(sys_if.rst), 64'd1);
        check("async_ft601", 64'(sys_if.ft601_rst_n), 64'd0);
        check("async_tick", sys_if.tickcount64, 64'd0);
        $display("async reset mid-wake: wake_n=%0b rst=%0b tick=%0d",
                 sys_if.pcie_wake_n, sys_if.rst, sys_if.tickcount64);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rst_seq("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
